// File: rtl/branch_pkg.sv
// Shared definitions for the branch controller: control-op and FSM encodings
// plus the constant jump-target LUT indexed by the instruction's lut_idx field.
package branch_pkg;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_BR_REL = 3'd1,
    OP_BR_ABS = 3'd2,
    OP_BEQZ   = 3'd3,
    OP_BNEZ   = 3'd4,
    OP_CALL   = 3'd5,
    OP_RET    = 3'd6,
    OP_HALT   = 3'd7
  } op_kind_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DONE  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam int LUT_DW = 12;
  localparam int LUT_LW = 5;
  localparam int LUT_N  = 2 ** LUT_LW;

  // Relative entries are two's complement offsets; absolute ones are addresses.
  localparam logic [LUT_DW-1:0] JUMP_LUT [LUT_N] = '{
    12'h000, 12'hFFE, 12'h100, 12'h040, 12'h008, 12'hFF0, 12'h200, 12'hFFC,
    12'h010, 12'h020, 12'h080, 12'h300, 12'hFF8, 12'h004, 12'h400, 12'hFE0,
    12'h011, 12'h022, 12'h044, 12'h088, 12'h0F0, 12'h7FF, 12'h800, 12'hF00,
    12'h123, 12'h234, 12'h345, 12'h456, 12'h567, 12'h678, 12'hABC, 12'hFFF
  };

  function automatic logic [LUT_DW-1:0] lut_read(input logic [LUT_LW-1:0] idx);
    return JUMP_LUT[idx];
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Push on full and pop on empty are dropped here; the
// controller detects those cases and faults before asking.
module ret_stack #(
  parameter  int DW  = 12,
  parameter  int SD  = 4,
  localparam int DPW = $clog2(SD + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [DW-1:0]  din_i,
  output logic [DW-1:0]  top_o,
  output logic [DPW-1:0] depth_o,
  output logic           full_o,
  output logic           empty_o
);

  logic [SD-1:0][DW-1:0] mem_q;
  logic [DPW-1:0]        depth_q, depth_d;
  logic                  do_push, do_pop;

  assign full_o  = (depth_q == DPW'(SD));
  assign empty_o = (depth_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o & ~push_i;
  assign depth_o = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + DPW'(1);
    else if (do_pop) depth_d = depth_q - DPW'(1);
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < SD; i++)
      if (depth_q == DPW'(i + 1)) top_o = mem_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
      for (int i = 0; i < SD; i++)
        if (do_push && depth_q == DPW'(i)) mem_q[i] <= din_i;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/call/return controller. Jump enables and target are combinational so
// the PC stage consumes them on the same edge; HALT or stack misuse parks the FSM.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter  int D   = 12,
  parameter  int SD  = 4,
  parameter  int LW  = 5,
  localparam int DPW = $clog2(SD + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [D-1:0]   prog_ctr,
  input  logic           op_valid,
  input  logic [2:0]     op_kind,
  input  logic [LW-1:0]  lut_idx,
  input  logic           zero_flag,
  output logic           reljump_en,
  output logic           absjump_en,
  output logic [D-1:0]   target,
  output logic           Done,
  output logic           stack_err,
  output logic [DPW-1:0] depth
);

  state_e         state_q, state_d;
  logic           done_q, err_q, err_d;
  logic           push, pop;
  logic [D-1:0]   lut_val, stk_top;
  logic           stk_full, stk_empty;

  assign lut_val = D'(lut_read(LUT_LW'(lut_idx)));

  ret_stack #(.DW(D), .SD(SD)) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (prog_ctr + D'(1)),
    .top_o   (stk_top),
    .depth_o (depth),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    reljump_en = 1'b0;
    absjump_en = 1'b0;
    target     = '0;
    push       = 1'b0;
    pop        = 1'b0;
    err_d      = err_q;
    state_d    = state_q;
    // Terminal states ignore everything; only RUN decodes ops.
    if (state_q == ST_RUN && op_valid) begin
      case (op_kind_e'(op_kind))
        OP_BR_REL: begin reljump_en = 1'b1;       target = lut_val; end
        OP_BR_ABS: begin absjump_en = 1'b1;       target = lut_val; end
        OP_BEQZ:   begin reljump_en = zero_flag;  target = lut_val; end
        OP_BNEZ:   begin reljump_en = ~zero_flag; target = lut_val; end
        OP_CALL: begin
          if (!stk_full) begin
            absjump_en = 1'b1;
            target     = lut_val;
            push       = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FAULT;
          end
        end
        OP_RET: begin
          if (!stk_empty) begin
            absjump_en = 1'b1;
            target     = stk_top;
            pop        = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FAULT;
          end
        end
        OP_HALT: state_d = ST_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d != ST_RUN);
      err_q   <= err_d;
    end
  end

  assign Done      = done_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: each applied op pushes its expected output
// vector from a behavioural model; the scenario task pops and compares it.
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int D = 12, SD = 4, LW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [D-1:0]  prog_ctr = '0;
  logic          op_valid = 1'b0;
  logic [2:0]    op_kind = 3'd0;
  logic [LW-1:0] lut_idx = '0;
  logic          zero_flag = 1'b0;
  logic          reljump_en, absjump_en, Done, stack_err;
  logic [D-1:0]  target;
  logic [2:0]    depth;

  branch_ctrl #(.D(D), .SD(SD), .LW(LW)) dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .op_valid(op_valid),
    .op_kind(op_kind), .lut_idx(lut_idx), .zero_flag(zero_flag),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .target(target),
    .Done(Done), .stack_err(stack_err), .depth(depth)
  );

  always #5 clk = ~clk;

  typedef logic [18:0] vec_t;  // {rel, abs, target, depth, stack_err, Done}
  vec_t obs;
  assign obs = {reljump_en, absjump_en, target, depth, stack_err, Done};

  vec_t         sb[$];
  vec_t         e;
  int           n_tests = 0, n_fail = 0;
  logic [D-1:0] m_stk[$];
  int           m_state = 0;  // 0 run, 1 done, 2 fault
  logic         m_err = 1'b0, m_done = 1'b0;

  function automatic logic [D-1:0] tb_lut(input logic [LW-1:0] i);
    case (i)
      5'd1:    return 12'hFFE;
      5'd2:    return 12'h100;
      5'd3:    return 12'h040;
      5'd4:    return 12'h008;
      5'd5:    return 12'hFF0;
      default: return 12'h000;
    endcase
  endfunction

  task automatic model_clear();
    m_stk.delete(); sb.delete();
    m_state = 0; m_err = 1'b0; m_done = 1'b0;
  endtask

  // Drive one op at negedge, record the expectation, sample point is +1.
  task automatic apply(input logic v, input op_kind_e k, input logic [LW-1:0] idx,
                       input logic [D-1:0] pc, input logic zf);
    logic rel, abs, err_n;
    logic [D-1:0] t;
    int sz, nst;
    @(negedge clk);
    op_valid = v; op_kind = k; lut_idx = idx; prog_ctr = pc; zero_flag = zf;
    rel = 1'b0; abs = 1'b0; t = '0; err_n = m_err; nst = m_state;
    sz = m_stk.size();
    if (m_state == 0 && v) begin
      case (k)
        OP_BR_REL: begin rel = 1'b1; t = tb_lut(idx); end
        OP_BR_ABS: begin abs = 1'b1; t = tb_lut(idx); end
        OP_BEQZ:   begin rel = zf;   t = tb_lut(idx); end
        OP_BNEZ:   begin rel = !zf;  t = tb_lut(idx); end
        OP_CALL:
          if (sz < SD) begin abs = 1'b1; t = tb_lut(idx); m_stk.push_back(pc + 12'd1); end
          else begin err_n = 1'b1; nst = 2; end
        OP_RET:
          if (sz > 0) begin abs = 1'b1; t = m_stk[$]; void'(m_stk.pop_back()); end
          else begin err_n = 1'b1; nst = 2; end
        OP_HALT:   nst = 1;
        default: ;
      endcase
    end
    sb.push_back({rel, abs, t, 3'(sz), m_err, m_done});
    m_err = err_n; m_state = nst; m_done = (nst != 0);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; op_valid = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (obs !== '0) begin n_fail++; $display("FAIL reset_state: got %h exp %h", obs, 19'h0); end
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_branch();
    apply(1, OP_BR_ABS, 5'd3, 12'h000, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL br_abs: got %h exp %h", obs, e); end
    n_tests++; if ({reljump_en, absjump_en, target} !== {1'b0, 1'b1, 12'h040}) begin n_fail++; $display("FAIL br_abs_const: got %b%b %h exp 01 040", reljump_en, absjump_en, target); end
    apply(1, OP_BEQZ, 5'd1, 12'h001, 1);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL beqz_taken: got %h exp %h", obs, e); end
    n_tests++; if ({reljump_en, absjump_en, target} !== {1'b1, 1'b0, 12'hFFE}) begin n_fail++; $display("FAIL beqz_const: got %b%b %h exp 10 ffe", reljump_en, absjump_en, target); end
    apply(1, OP_BEQZ, 5'd1, 12'h002, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL beqz_not: got %h exp %h", obs, e); end
    n_tests++; if ({reljump_en, absjump_en} !== 2'b00) begin n_fail++; $display("FAIL beqz_not_en: got %b%b exp 00", reljump_en, absjump_en); end
    // back-to-back mixed traffic, including idle and invalid ops
    apply(1, OP_BR_REL, 5'd5, 12'h003, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL br_rel: got %h exp %h", obs, e); end
    apply(1, OP_BNEZ, 5'd4, 12'h004, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL bnez_taken: got %h exp %h", obs, e); end
    apply(1, OP_BNEZ, 5'd4, 12'h005, 1);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL bnez_not: got %h exp %h", obs, e); end
    apply(0, OP_BR_ABS, 5'd3, 12'h006, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL invalid_op: got %h exp %h", obs, e); end
    apply(1, OP_NONE, 5'd3, 12'h007, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL op_none: got %h exp %h", obs, e); end
  endtask

  task automatic test_call_ret();
    do_reset();
    apply(1, OP_CALL, 5'd2, 12'h010, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL call: got %h exp %h", obs, e); end
    apply(1, OP_NONE, 5'd0, 12'h100, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL call_depth: got %h exp %h", obs, e); end
    n_tests++; if (depth !== 3'd1) begin n_fail++; $display("FAIL call_depth_const: got %0d exp 1", depth); end
    apply(1, OP_RET, 5'd0, 12'h101, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL ret: got %h exp %h", obs, e); end
    n_tests++; if ({absjump_en, target} !== {1'b1, 12'h011}) begin n_fail++; $display("FAIL ret_const: got %b %h exp 1 011", absjump_en, target); end
    apply(1, OP_NONE, 5'd0, 12'h011, 0);
    n_tests++; if (depth !== 3'd0) begin n_fail++; $display("FAIL ret_depth: got %0d exp 0", depth); end
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL ret_depth_sb: got %h exp %h", obs, e); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1, OP_CALL, 5'd4, 12'h200 + 12'(i), 0);
      e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL call_%0d: got %h exp %h", i, obs, e); end
    end
    n_tests++; if ({reljump_en, absjump_en} !== 2'b00) begin n_fail++; $display("FAIL ovf_nojump: got %b%b exp 00", reljump_en, absjump_en); end
    apply(1, OP_BR_ABS, 5'd3, 12'h300, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL ovf_after: got %h exp %h", obs, e); end
    n_tests++; if ({depth, stack_err, Done} !== {3'd4, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ovf_const: got %0d %b %b exp 4 1 1", depth, stack_err, Done); end
  endtask

  task automatic test_underflow();
    do_reset();
    apply(1, OP_RET, 5'd0, 12'h020, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL unf_ret: got %h exp %h", obs, e); end
    apply(1, OP_BR_ABS, 5'd3, 12'h021, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL unf_ignored: got %h exp %h", obs, e); end
    n_tests++; if ({absjump_en, stack_err, Done} !== 3'b011) begin n_fail++; $display("FAIL unf_const: got %b%b%b exp 011", absjump_en, stack_err, Done); end
    @(negedge clk); #2 reset = 1'b0;
    #1;
    n_tests++; if ({stack_err, Done, depth} !== 5'b0) begin n_fail++; $display("FAIL unf_reset: got %b %b %0d exp 0 0 0", stack_err, Done, depth); end
    model_clear();
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_halt_wrap();
    do_reset();
    apply(1, OP_CALL, 5'd2, 12'hFFF, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL wrap_call: got %h exp %h", obs, e); end
    apply(1, OP_RET, 5'd0, 12'h100, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL wrap_ret: got %h exp %h", obs, e); end
    n_tests++; if ({absjump_en, target} !== {1'b1, 12'h000}) begin n_fail++; $display("FAIL wrap_const: got %b %h exp 1 000", absjump_en, target); end
    apply(1, OP_HALT, 5'd0, 12'h001, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL halt: got %h exp %h", obs, e); end
    for (int i = 0; i < 10; i++) begin
      apply(1, op_kind_e'(3'($urandom_range(0, 7))), 5'($urandom_range(0, 5)), 12'($urandom), 1'($urandom));
      e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL halt_hold_%0d: got %h exp %h", i, obs, e); end
      n_tests++; if ({reljump_en, absjump_en, Done} !== 3'b001) begin n_fail++; $display("FAIL halt_const_%0d: got %b%b%b exp 001", i, reljump_en, absjump_en, Done); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(1, OP_CALL, 5'd2, 12'h040, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL mid_call1: got %h exp %h", obs, e); end
    apply(1, OP_CALL, 5'd2, 12'h050, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL mid_call2: got %h exp %h", obs, e); end
    #1 reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    n_tests++; if (depth !== 3'd0) begin n_fail++; $display("FAIL mid_discard: got %0d exp 0", depth); end
    @(negedge clk); reset = 1'b1; op_valid = 1'b0;
    apply(1, OP_CALL, 5'd2, 12'h060, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL mid_fresh_call: got %h exp %h", obs, e); end
    apply(1, OP_RET, 5'd0, 12'h100, 0);
    e = sb.pop_front(); n_tests++; if (obs !== e) begin n_fail++; $display("FAIL mid_fresh_ret: got %h exp %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_halt_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter D, default 12, width of program counter and jump target.
REQ-002 Parameter SD, default 4, return-stack depth in entries.
REQ-003 Parameter LW, default 5, jump-LUT index width (2**LW entries).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low; clears all state on assertion, independent of clk.
REQ-006 prog_ctr  input  D  current program counter from the PC stage.
REQ-007 op_valid  input  1  current instruction carries a control op.
REQ-008 op_kind  input  3  control op: NONE, BR_REL, BR_ABS, BEQZ, BNEZ, CALL, RET, HALT.
REQ-009 lut_idx  input  LW  jump-LUT index for branch, jump and call ops.
REQ-010 zero_flag  input  1  ALU zero flag, sampled combinationally in the op cycle.
REQ-011 reljump_en  output  1  PC adds target this edge.
REQ-012 absjump_en  output  1  PC loads target this edge.
REQ-013 target  output  D  relative offset (two's complement) or absolute address.
REQ-014 Done  output  1  halts the PC; high in DONE and FAULT.
REQ-015 stack_err  output  1  sticky; return-stack overflow or underflow occurred.
REQ-016 depth  output  $clog2(SD+1)  current return-stack occupancy.

Function
REQ-017 FSM states RUN, DONE, FAULT; reset state RUN.
REQ-018 Jump outputs are combinational from the op inputs and the current state; the PC consumes them at the same edge (zero-cycle latency).
REQ-019 RUN, op_valid=0 or op_kind=NONE: reljump_en=0, absjump_en=0, target=0; no state change.
REQ-020 BR_REL: reljump_en=1, target=lut[lut_idx].
REQ-021 BR_ABS: absjump_en=1, target=lut[lut_idx].
REQ-022 BEQZ: reljump_en=zero_flag; BNEZ: reljump_en=~zero_flag; target=lut[lut_idx] in both cases, taken or not.
REQ-023 CALL with depth<SD: absjump_en=1, target=lut[lut_idx], and prog_ctr+1 (mod 2**D) is pushed at the edge.
REQ-024 RET with depth>0: absjump_en=1, target=top-of-stack, and the entry is popped at the edge.
REQ-025 HALT: no jump; FSM goes to DONE at the edge.
REQ-026 CALL with depth==SD: no jump, no push, stack_err set, FSM goes to FAULT.
REQ-027 RET with depth==0: no jump, no pop, stack_err set, FSM goes to FAULT.
REQ-028 DONE and FAULT are terminal until reset; in both, jump enables are 0, the stack is frozen and all ops are ignored.
REQ-029 Done equals (state!=RUN), registered; it rises the cycle after the HALT or fault edge.
REQ-030 reljump_en and absjump_en are never both high.

Reset
REQ-031 Reset low: state=RUN, depth=0, stack_err=0, Done=0, all stack entries=0, asynchronously.
REQ-032 Reset mid-CALL or mid-RET discards the push or pop; after deassertion the block behaves as freshly reset.

Structure
REQ-033 The op_kind enum, the FSM state enum and the LUT contents (constant array of D-bit entries) are defined in package branch_pkg.
REQ-034 Sub-module ret_stack: LIFO with push, pop, top, depth, full and empty; branch_ctrl instantiates it once.

Verification
REQ-035 Reset, then BR_ABS with lut[3]=0x040 -> absjump_en=1, target=0x040, reljump_en=0.
REQ-036 BEQZ with lut[1]=0xFFE, zero_flag=1 -> reljump_en=1, target=0xFFE; same op with zero_flag=0 -> both enables 0.
REQ-037 CALL at prog_ctr=0x010 (lut[2]=0x100), then RET -> depth goes 1 then 0; RET target=0x011.
REQ-038 Five CALLs with SD=4 -> the fifth gives no jump, stack_err=1, Done=1 next cycle, depth stays 4.
REQ-039 RET on empty stack -> stack_err=1, FAULT; subsequent BR_ABS ignored; reset low -> stack_err=0, Done=0.
REQ-040 HALT -> Done=1 next cycle and held for 10 cycles despite op traffic; CALL at prog_ctr=0xFFF pushes 0x000 (wrap).
